// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port among write buffer, dcache and icache.
// Define MEM_ARB_STARVE_GUARD_EN to let starved cache requesters outrank the write buffer.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no transaction; grant when memory is ready and any req is high
// ISSUE | mem_en high until memory signals acceptance (mem_done low)
// WAIT  | memory busy; completion when mem_done returns high
// RESP  | done pulse visible to owner; owner released on exit
module mem_arbiter #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int MAXWAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          swc,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_data,
  input  logic [3:0]    wb_byteen,
  output logic          wb_done,
  input  logic          d_req,
  input  logic [AW-1:0] d_adr,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  input  logic          i_req,
  input  logic [AW-1:0] i_adr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_byteen,
  output logic          mem_rwb,
  output logic          mem_en,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WB   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_I    = 2'd3;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_owner;
  logic [AW-1:0]   r_mem_adr;
  logic [DW-1:0]   r_mem_wdata;
  logic [3:0]      r_mem_byteen;
  logic            r_mem_rwb;
  logic            r_mem_en;
  logic            r_wb_done;
  logic            r_d_done;
  logic            r_i_done;
  logic [DW-1:0]   r_d_rdata;
  logic [DW-1:0]   r_i_rdata;
  logic [1:0]      w_grant;
  logic            w_start;
  logic [3:0]      w_cnt_d;
  logic [3:0]      w_cnt_i;
  logic            w_d_starved;
  logic            w_i_starved;

  assign w_d_starved = STARVE_EN && d_req && (int'(w_cnt_d) >= MAXWAIT);
  assign w_i_starved = STARVE_EN && i_req && (int'(w_cnt_i) >= MAXWAIT);

  always_comb begin
    w_grant = OWN_NONE;
    if (w_d_starved && w_i_starved) w_grant = swc ? OWN_I : OWN_D;
    else if (w_d_starved)           w_grant = OWN_D;
    else if (w_i_starved)           w_grant = OWN_I;
    else if (wb_req)                w_grant = OWN_WB;
    else if (d_req && !(swc && i_req)) w_grant = OWN_D;
    else if (i_req)                 w_grant = OWN_I;
  end

  // Never start while memory is still busy from someone else.
  assign w_start = (r_state == S_IDLE) && mem_done && (w_grant != OWN_NONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start)   w_state_nxt = S_ISSUE;
      S_ISSUE: if (!mem_done) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_done)  w_state_nxt = S_RESP;
      S_RESP:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWN_NONE;
      r_mem_adr    <= '0;
      r_mem_wdata  <= '0;
      r_mem_byteen <= '0;
      r_mem_rwb    <= 1'b1;
      r_mem_en     <= 1'b0;
      r_wb_done    <= 1'b0;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_rdata    <= '0;
      r_i_rdata    <= '0;
    end else begin
      r_wb_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_owner  <= w_grant;
            r_mem_en <= 1'b1;
            if (w_grant == OWN_WB) begin
              r_mem_adr    <= wb_adr;
              r_mem_wdata  <= wb_data;
              r_mem_byteen <= wb_byteen;
              r_mem_rwb    <= 1'b0;
            end else begin
              r_mem_adr    <= (w_grant == OWN_D) ? d_adr : i_adr;
              r_mem_byteen <= 4'b1111;
              r_mem_rwb    <= 1'b1;
            end
          end
        end
        S_ISSUE: if (!mem_done) r_mem_en <= 1'b0;
        S_WAIT: begin
          if (mem_done) begin
            unique case (r_owner)
              OWN_WB: r_wb_done <= 1'b1;
              OWN_D: begin
                r_d_done  <= 1'b1;
                r_d_rdata <= mem_rdata;
              end
              OWN_I: begin
                r_i_done  <= 1'b1;
                r_i_rdata <= mem_rdata;
              end
              default: ;
            endcase
          end
        end
        S_RESP: r_owner <= OWN_NONE;
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_cnt_d;
  logic [3:0] r_cnt_i;

  // A loss only counts when a grant actually happens in IDLE while the req is up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_d <= '0;
      r_cnt_i <= '0;
    end else begin
      if (!d_req || (w_start && (w_grant == OWN_D)))   r_cnt_d <= '0;
      else if (w_start && (r_cnt_d != 4'hF))           r_cnt_d <= r_cnt_d + 4'd1;
      if (!i_req || (w_start && (w_grant == OWN_I)))   r_cnt_i <= '0;
      else if (w_start && (r_cnt_i != 4'hF))           r_cnt_i <= r_cnt_i + 4'd1;
    end
  end

  assign w_cnt_d = r_cnt_d;
  assign w_cnt_i = r_cnt_i;
`else
  assign w_cnt_d = '0;
  assign w_cnt_i = '0;
`endif

  assign owner      = r_owner;
  assign mem_adr    = r_mem_adr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_byteen = r_mem_byteen;
  assign mem_rwb    = r_mem_rwb;
  assign mem_en     = r_mem_en;
  assign wb_done    = r_wb_done;
  assign d_done     = r_d_done;
  assign i_done     = r_i_done;
  assign d_rdata    = r_d_rdata;
  assign i_rdata    = r_i_rdata;

endmodule
